// File: rtl/oam_dma_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl_pkg
// Description : Shared types and address constants for the sprite DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
package oam_dma_ctrl_pkg;

    typedef logic [7:0] reg_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] c_dma_reg_addr = 16'h4014;
    localparam logic [15:0] c_oamdata_addr = 16'h2004;
    localparam int          c_num_bytes    = 256;

endpackage
`default_nettype wire

// File: rtl/oam_dma_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl_if
// Description : CPU snoop inputs and DMA bus-master outputs of the OAM DMA.
// Revision    : 1.0 - initial release
// ============================================================================
interface oam_dma_ctrl_if;

    logic [15:0] cpu_addr;
    logic        cpu_r_en;
    logic [7:0]  cpu_w_data;
    logic [7:0]  mem_r_data;
    logic        cpu_halt;
    logic [15:0] dma_addr;
    logic        dma_r_en;
    logic [7:0]  dma_w_data;
    logic        dma_done;

    modport master (
        input  cpu_addr, cpu_r_en, cpu_w_data, mem_r_data,
        output cpu_halt, dma_addr, dma_r_en, dma_w_data, dma_done
    );

    modport slave (
        output cpu_addr, cpu_r_en, cpu_w_data, mem_r_data,
        input  cpu_halt, dma_addr, dma_r_en, dma_w_data, dma_done
    );

endinterface
`default_nettype wire

// File: rtl/cpu_cycle_parity.sv
`default_nettype none
// ============================================================================
// Module      : cpu_cycle_parity
// Description : Even/odd CPU cycle tracker; toggles once per enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_cycle_parity (
    input  logic clock,
    input  logic reset,
    input  logic i_clock_en,
    output logic o_parity
);

    logic r_parity;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (i_clock_en) begin
            r_parity <= ~r_parity;
        end
    end

    assign o_parity = r_parity;

endmodule
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_ctrl
// Description : Sprite DMA - halts the CPU on a $4014 store and copies one
//               256-byte page into OAMDATA as alternating read/write cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = c_dma_reg_addr,
    parameter logic [15:0] OAMDATA_ADDR = c_oamdata_addr,
    parameter int          NUM_BYTES    = c_num_bytes
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clock_en,
    oam_dma_ctrl_if.master bus
);

    localparam int               IDX_W      = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_BYTES - 1);

    dma_state_t       r_state;
    dma_state_t       w_next_state;
    reg_t             r_page;
    logic [IDX_W-1:0] r_byte_idx;
    logic             r_done;
    logic             w_parity;
    logic             w_trigger;
    logic             w_last;
    logic [15:0]      w_page_base;
    logic [15:0]      w_src_addr;

    cpu_cycle_parity u_parity (
        .clock      (clock),
        .reset      (reset),
        .i_clock_en (clock_en),
        .o_parity   (w_parity)
    );

    // Only an idle engine listens; stores to $4014 mid-copy never reach us anyway.
    assign w_trigger   = (r_state == IDLE) && (bus.cpu_addr == DMA_REG_ADDR) && !bus.cpu_r_en;
    assign w_last      = (r_byte_idx == c_last_idx);
    assign w_page_base = {r_page, 8'h00};
    assign w_src_addr  = w_page_base | 16'(r_byte_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (clock_en) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_trigger) w_next_state = HALT;
            // Reads must land on even cycles; an odd-parity halt needs no padding.
            HALT:    w_next_state = w_parity ? READ : ALIGN;
            ALIGN:   w_next_state = READ;
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = w_last ? IDLE : READ;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_page     <= '0;
            r_byte_idx <= '0;
            r_done     <= 1'b0;
        end else if (clock_en) begin
            r_done <= (r_state == WRITE) && w_last;
            if (w_trigger) begin
                r_page     <= bus.cpu_w_data;
                r_byte_idx <= '0;
            end else if ((r_state == WRITE) && !w_last) begin
                r_byte_idx <= r_byte_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        bus.cpu_halt   = (r_state != IDLE);
        bus.dma_addr   = 16'h0000;
        bus.dma_r_en   = 1'b1;
        bus.dma_w_data = 8'h00;
        bus.dma_done   = r_done;
        case (r_state)
            HALT, ALIGN: bus.dma_addr = w_page_base;
            READ:        bus.dma_addr = w_src_addr;
            WRITE: begin
                bus.dma_addr   = OAMDATA_ADDR;
                bus.dma_r_en   = 1'b0;
                bus.dma_w_data = bus.mem_r_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
